// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared types and constants for the decimal arithmetic unit.
// Provides the BCD digit type, the serial subtractor state encoding,
// the decimal radix and largest legal digit, and a digit-validity helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } bcd_state_e;

  localparam int         BCD_RADIX     = 10;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // A nibble above 9 is not a decimal digit.
  function automatic logic bcdDigitInvalid(input bcd_digit_t d);
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_sub_1dgt.sv
// bcd_sub_1dgt
// Combinational single-digit BCD subtract step: t = x - y - borrow_in.
// A negative t is folded back into 0..9 by adding the radix and raises
// borrow_out.
// Ports:
//   x          in  4  minuend digit
//   y          in  4  subtrahend digit
//   borrow_in  in  1  borrow from the next lower digit
//   digit      out 4  result digit
//   borrow_out out 1  borrow into the next higher digit
module bcd_sub_1dgt
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  // Five bits hold every case, including non-decimal nibbles
  // (range -16..15), so bit 4 is an exact sign bit.
  logic [4:0] rawDiff;

  assign rawDiff    = {1'b0, x} - {1'b0, y} - {4'b0000, borrow_in};
  assign borrow_out = rawDiff[4];
  assign digit      = rawDiff[4] ? (rawDiff[3:0] + 4'(BCD_RADIX)) : rawDiff[3:0];

endmodule

// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial
// Digit-serial packed-BCD subtractor returning |a - b| and a sign flag,
// one digit per clock, least significant digit first. A negative raw
// result is turned into its magnitude by a second tens-complement pass
// (10^DIGITS - raw) through the same digit step.
// Optional feature macro: BCD_SUB_INVALID_CHECK_EN -- when defined, any
// operand nibble above 9 at start is flagged and reported through err
// (with diff=0, neg=0); when undefined, err is always 0.
// Ports:
//   clk   in  1          rising-edge clock
//   rst   in  1          synchronous active-high reset
//   start in  1          operation request, sampled only in IDLE
//   a     in  4*DIGITS   minuend, packed BCD
//   b     in  4*DIGITS   subtrahend, packed BCD
//   busy  out 1          high while digits are being processed
//   done  out 1          one-cycle pulse when diff/neg/err are valid
//   diff  out 4*DIGITS   |a - b| in BCD, held until the next result
//   neg   out 1          1 when a < b
//   err   out 1          invalid-digit flag
module bcd_subtractor_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  bcd_state_e    state_q;
  logic [W-1:0]  aSh_q, bSh_q, res_q;
  logic [W-1:0]  aSh_d, bSh_d, res_d;
  logic [IW-1:0] idx_q;
  logic          borrow_q;
  logic          negPending_q;
  logic          busy_q, done_q, neg_q, err_q;
  logic [W-1:0]  diff_q;

  bcd_digit_t    subX, subY, subDigit;
  logic          subBorrow;
  logic          errNow;

  // The shared digit step: SUB consumes operand digits, FIX subtracts the
  // raw result from zero. Both read the low nibble of the shift registers.
  always_comb begin
    subX = aSh_q[3:0];
    subY = bSh_q[3:0];
    if (state_q == FIX) begin
      subX = '0;
      subY = res_q[3:0];
    end
  end

  bcd_sub_1dgt u_digit (
    .x          (subX),
    .y          (subY),
    .borrow_in  (borrow_q),
    .digit      (subDigit),
    .borrow_out (subBorrow)
  );

  // Operands shift down one digit per step; each new result digit enters
  // at the top, so after DIGITS steps the result sits in natural order and
  // the FIX pass can re-read it from the bottom in the same way.
  always_comb begin
    aSh_d = aSh_q >> 4;
    bSh_d = bSh_q >> 4;
    res_d = (res_q >> 4) | (W'(subDigit) << (W - 4));
  end

`ifdef BCD_SUB_INVALID_CHECK_EN
  logic errSticky_q;
  logic startInvalid_d;

  always_comb begin
    startInvalid_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdDigitInvalid(a[4*i +: 4]) || bcdDigitInvalid(b[4*i +: 4])) begin
        startInvalid_d = 1'b1;
      end
    end
  end

  assign errNow = errSticky_q;
`else
  assign errNow = 1'b0;
`endif

  // Control FSM and all datapath registers. Outputs are updated only in
  // DONE, so diff/neg/err stay stable through the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      aSh_q        <= '0;
      bSh_q        <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      negPending_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      neg_q        <= 1'b0;
      err_q        <= 1'b0;
`ifdef BCD_SUB_INVALID_CHECK_EN
      errSticky_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            aSh_q        <= a;
            bSh_q        <= b;
            res_q        <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            negPending_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= SUB;
`ifdef BCD_SUB_INVALID_CHECK_EN
            errSticky_q  <= startInvalid_d;
`endif
          end
        end

        SUB: begin
          aSh_q    <= aSh_d;
          bSh_q    <= bSh_d;
          res_q    <= res_d;
          borrow_q <= subBorrow;
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            // A final borrow means a < b; flagged operands never take the
            // correction pass because their result is discarded anyway.
            if (subBorrow && !errNow) begin
              borrow_q <= 1'b0;
              state_q  <= FIX;
            end else begin
              busy_q       <= 1'b0;
              negPending_q <= 1'b0;
              state_q      <= DONE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        FIX: begin
          res_q    <= res_d;
          borrow_q <= subBorrow;
          if (idx_q == LAST_IDX) begin
            idx_q        <= '0;
            busy_q       <= 1'b0;
            negPending_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          diff_q  <= errNow ? '0 : res_q;
          neg_q   <= errNow ? 1'b0 : negPending_q;
          err_q   <= errNow;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial
// Directed bench for the 4-digit serial BCD subtractor. Each operation
// records the edge at which busy falls and the edge at which done appears
// (counted from the start edge) and compares them and the results with
// hand-computed values. Define BCD_SUB_INVALID_CHECK_EN to also cover the
// invalid-digit path.
module tb_bcd_subtractor_serial;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, neg, err;
  logic [15:0] diff;

  int checks = 0;
  int errors = 0;

  int busyEdge, doneEdge, sawDone;

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one operation and waits (bounded) for done. With hold set, start
  // stays high and the operands are changed during busy; start is dropped
  // only once done has been seen.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input bit hold, output int busyAt,
                               output int doneAt);
    busyAt = -1;
    doneAt = -1;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busyAfterStart", {31'b0, busy}, 32'd1);
    if (hold) begin
      a = 16'h9999;
      b = 16'h0001;
    end else begin
      start = 1'b0;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (!busy && busyAt < 0) busyAt = n;
      if (done) begin
        doneAt = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Runs one operation and checks timing, result and the single-cycle done.
  task automatic runOp(input string tag, input logic [15:0] av,
                       input logic [15:0] bv, input bit hold,
                       input logic [15:0] expDiff, input logic expNeg,
                       input logic expErr, input int expBusyEdge,
                       input int expDoneEdge);
    applyStimulus(av, bv, hold, busyEdge, doneEdge);
    checkOutput({tag, ".busyEdge"}, 32'(busyEdge), 32'(expBusyEdge));
    checkOutput({tag, ".doneEdge"}, 32'(doneEdge), 32'(expDoneEdge));
    checkOutput({tag, ".diff"}, {16'b0, diff}, {16'b0, expDiff});
    checkOutput({tag, ".neg"}, {31'b0, neg}, {31'b0, expNeg});
    checkOutput({tag, ".err"}, {31'b0, err}, {31'b0, expErr});
    @(posedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, ".diffHeld"}, {16'b0, diff}, {16'b0, expDiff});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", {31'b0, busy}, 32'd0);
    checkOutput("reset.done", {31'b0, done}, 32'd0);
    checkOutput("reset.diff", {16'b0, diff}, 32'd0);
    checkOutput("reset.neg",  {31'b0, neg},  32'd0);
    checkOutput("reset.err",  {31'b0, err},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-negative: latency DIGITS+1, busy falls at edge DIGITS.
    runOp("p42m17", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 4, 5);
    // Negative: raw 9975 is corrected to 0025; latency 2*DIGITS+1.
    runOp("p17m42", 16'h0017, 16'h0042, 1'b0, 16'h0025, 1'b1, 1'b0, 8, 9);
    runOp("p0m9999", 16'h0000, 16'h9999, 1'b0, 16'h9999, 1'b1, 1'b0, 8, 9);
    runOp("p9999m0", 16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0, 4, 5);
    // Equal operands must yield a positive zero.
    runOp("equal", 16'h5050, 16'h5050, 1'b0, 16'h0000, 1'b0, 1'b0, 4, 5);
    runOp("p1000m1", 16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 4, 5);

    // start held high with operands changed during busy: only the first
    // captured pair matters and done pulses exactly once.
    runOp("holdStart", 16'h0042, 16'h0017, 1'b1, 16'h0025, 1'b0, 1'b0, 4, 5);
    sawDone = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) sawDone++;
    end
    checkOutput("holdStart.extraDone", 32'(sawDone), 32'd0);
    checkOutput("holdStart.idleBusy", {31'b0, busy}, 32'd0);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    a     = 16'h0017;
    b     = 16'h0042;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRst.busy", {31'b0, busy}, 32'd0);
    checkOutput("midRst.diff", {16'b0, diff}, 32'd0);
    checkOutput("midRst.neg",  {31'b0, neg},  32'd0);
    checkOutput("midRst.done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) sawDone++;
    end
    checkOutput("midRst.noDone", 32'(sawDone), 32'd0);
    runOp("afterRst", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 4, 5);

`ifdef BCD_SUB_INVALID_CHECK_EN
    runOp("invalid", 16'h00A1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 4, 5);
    // A valid operation afterwards clears the error flag.
    runOp("postInvalid", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 4, 5);
`else
    applyStimulus(16'h00A1, 16'h0001, 1'b0, busyEdge, doneEdge);
    checkOutput("noCheck.doneEdge", 32'(doneEdge), 32'd5);
    checkOutput("noCheck.err", {31'b0, err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
